// File: rtl/counter_mod_nbit.sv
`default_nettype none
// ============================================================================
// counter_mod_nbit : WIDTH-bit up/down counter with sync load (clamped to LIMIT),
//                    combinational terminal carry/borrow and sticky ovf flag.
// Optional feature  : `COUNTER_SATURATE_EN (hold at boundary instead of wrap).
// Revision          : 1.0 - initial release
// ============================================================================
module counter_mod_nbit #(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned LIMIT   = (2**WIDTH) - 1,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             up,
    input  logic [WIDTH-1:0] in,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             co,
    output logic             ovf
);
    localparam logic [WIDTH-1:0] LIM     = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);

    logic             at_top;
    logic             at_zero;
    logic             term;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] wrap_val;
    logic [WIDTH-1:0] count_nxt;

    assign at_top   = (count == LIM);
    assign at_zero  = (count == '0);
    assign term     = up ? at_top : at_zero;
    // Combinational so a chained stage sees its enable in the same cycle.
    assign co       = en & ~load & term;
    assign load_val = (in > LIM) ? LIM : in;

`ifdef COUNTER_SATURATE_EN
    assign wrap_val = count;
`else
    assign wrap_val = up ? '0 : LIM;
`endif

    always_comb begin
        count_nxt = count;
        if (load) begin
            count_nxt = load_val;
        end else if (en) begin
            if (term) begin
                count_nxt = wrap_val;
            end else if (up) begin
                count_nxt = count + 1'b1;
            end else begin
                count_nxt = count - 1'b1;
            end
        end
    end

    // Set beats clear so a boundary event coinciding with clr_ovf is kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= RST_CNT;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            if (co) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_mod_nbit.sv
`default_nettype none
// ============================================================================
// tb_counter_mod_nbit : directed self-checking bench for counter_mod_nbit.
// Revision            : 1.0 - initial release
// ============================================================================
module tb_counter_mod_nbit;
    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       en      = 1'b0;
    logic       load    = 1'b0;
    logic       up      = 1'b1;
    logic       clr_ovf = 1'b0;
    logic       en_c    = 1'b0;
    logic [2:0] in_v    = 3'd0;
    logic [2:0] count;
    logic       co;
    logic       ovf;
    logic [3:0] lo_cnt, hi_cnt;
    logic       lo_co, hi_co, lo_ovf, hi_ovf;

    int vectors     = 0;
    int miscompares = 0;

`ifdef COUNTER_SATURATE_EN
    localparam logic [2:0] DN_FROM0 = 3'd0;
`else
    localparam logic [2:0] DN_FROM0 = 3'd5;
`endif

    always #5 clk = ~clk;

    counter_mod_nbit #(.WIDTH(3), .LIMIT(5), .RST_VAL(2)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .up(up), .in(in_v),
        .clr_ovf(clr_ovf), .count(count), .co(co), .ovf(ovf)
    );

    counter_mod_nbit #(.WIDTH(4), .LIMIT(9), .RST_VAL(0)) u_lo (
        .clk(clk), .rst(rst), .en(en_c), .load(1'b0), .up(1'b1), .in(4'd0),
        .clr_ovf(1'b0), .count(lo_cnt), .co(lo_co), .ovf(lo_ovf)
    );

    counter_mod_nbit #(.WIDTH(4), .LIMIT(9), .RST_VAL(0)) u_hi (
        .clk(clk), .rst(rst), .en(lo_co), .load(1'b0), .up(1'b1), .in(4'd0),
        .clr_ovf(1'b0), .count(hi_cnt), .co(hi_co), .ovf(hi_ovf)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        load = 1'b1; in_v = 3'd4;
        tick();
        vectors++;
        if (count !== 3'd4) begin miscompares++; $display("FAIL pre_reset_load: got %0d expected 4", count); end
        #3; rst = 1'b0; load = 1'b0;
        #1;
        vectors++;
        if (count !== 3'd2) begin miscompares++; $display("FAIL async_reset_count: got %0d expected 2", count); end
        vectors++;
        if (ovf !== 1'b0) begin miscompares++; $display("FAIL async_reset_ovf: got %0b expected 0", ovf); end
        vectors++;
        if ({hi_cnt, lo_cnt} !== 8'h00) begin miscompares++; $display("FAIL async_reset_cascade: got %h expected 00", {hi_cnt, lo_cnt}); end
        #1; rst = 1'b1;
        tick(); tick();
        vectors++;
        if (count !== 3'd2) begin miscompares++; $display("FAIL reset_hold: got %0d expected 2", count); end
    endtask

    task automatic test_up_wrap;
        logic [2:0] exp_cnt [7];
        logic       exp_co  [7];
        logic       exp_ovf [7];
`ifdef COUNTER_SATURATE_EN
        exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd5};
        exp_co  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
        exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
        exp_co  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
        exp_ovf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        load = 1'b1; in_v = 3'd0;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1;
            vectors++;
            if (co !== exp_co[i]) begin miscompares++; $display("FAIL up_co[%0d]: got %0b expected %0b", i, co, exp_co[i]); end
            tick();
            vectors++;
            if (count !== exp_cnt[i]) begin miscompares++; $display("FAIL up_count[%0d]: got %0d expected %0d", i, count, exp_cnt[i]); end
            vectors++;
            if (ovf !== exp_ovf[i]) begin miscompares++; $display("FAIL up_ovf[%0d]: got %0b expected %0b", i, ovf, exp_ovf[i]); end
        end
        en = 1'b0;
    endtask

    task automatic test_down_wrap_clear;
        load = 1'b1; in_v = 3'd1;
        tick();
        vectors++;
        if (count !== 3'd1) begin miscompares++; $display("FAIL dn_load: got %0d expected 1", count); end
        load = 1'b0; en = 1'b1; up = 1'b0;
        #1;
        vectors++;
        if (co !== 1'b0) begin miscompares++; $display("FAIL dn_co_at1: got %0b expected 0", co); end
        tick();
        vectors++;
        if (count !== 3'd0) begin miscompares++; $display("FAIL dn_count0: got %0d expected 0", count); end
        vectors++;
        if (co !== 1'b1) begin miscompares++; $display("FAIL dn_co_at0: got %0b expected 1", co); end
        tick();
        vectors++;
        if (count !== DN_FROM0) begin miscompares++; $display("FAIL dn_wrap: got %0d expected %0d", count, DN_FROM0); end
        en = 1'b0; clr_ovf = 1'b1;
        tick();
        vectors++;
        if (ovf !== 1'b0) begin miscompares++; $display("FAIL clr_ovf: got %0b expected 0", ovf); end
        clr_ovf = 1'b0; load = 1'b1; in_v = 3'd0;
        tick();
        vectors++;
        if (ovf !== 1'b0) begin miscompares++; $display("FAIL load_no_ovf: got %0b expected 0", ovf); end
        load = 1'b0; en = 1'b1; up = 1'b0; clr_ovf = 1'b1;
        tick();
        vectors++;
        if (ovf !== 1'b1) begin miscompares++; $display("FAIL set_beats_clr: got %0b expected 1", ovf); end
        vectors++;
        if (count !== DN_FROM0) begin miscompares++; $display("FAIL set_clr_count: got %0d expected %0d", count, DN_FROM0); end
        clr_ovf = 1'b0;
    endtask

    task automatic test_load_priority;
        load = 1'b1; in_v = 3'd7; en = 1'b1; up = 1'b1;
        #1;
        vectors++;
        if (co !== 1'b0) begin miscompares++; $display("FAIL load_co_mask1: got %0b expected 0", co); end
        tick();
        vectors++;
        if (count !== 3'd5) begin miscompares++; $display("FAIL load_clamp: got %0d expected 5", count); end
        vectors++;
        if (co !== 1'b0) begin miscompares++; $display("FAIL load_co_mask2: got %0b expected 0", co); end
        in_v = 3'd3;
        tick();
        vectors++;
        if (count !== 3'd3) begin miscompares++; $display("FAIL load_over_en: got %0d expected 3", count); end
        load = 1'b0;
        tick();
        vectors++;
        if (count !== 3'd4) begin miscompares++; $display("FAIL up_after_load: got %0d expected 4", count); end
        up = 1'b0;
        tick();
        vectors++;
        if (count !== 3'd3) begin miscompares++; $display("FAIL dir_change: got %0d expected 3", count); end
        en = 1'b0;
    endtask

    task automatic test_boundary;
        logic [2:0] exp_up [3];
        logic       co_up  [3];
        logic [2:0] exp_dn [2];
        logic       co_dn  [2];
`ifdef COUNTER_SATURATE_EN
        exp_up = '{3'd5, 3'd5, 3'd5}; co_up = '{1'b0, 1'b1, 1'b1};
        exp_dn = '{3'd0, 3'd0};       co_dn = '{1'b1, 1'b1};
`else
        exp_up = '{3'd5, 3'd0, 3'd1}; co_up = '{1'b0, 1'b1, 1'b0};
        exp_dn = '{3'd5, 3'd4};       co_dn = '{1'b1, 1'b0};
`endif
        clr_ovf = 1'b1; load = 1'b1; in_v = 3'd4;
        tick();
        vectors++;
        if (ovf !== 1'b0) begin miscompares++; $display("FAIL bnd_clr: got %0b expected 0", ovf); end
        clr_ovf = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (co !== co_up[i]) begin miscompares++; $display("FAIL bnd_up_co[%0d]: got %0b expected %0b", i, co, co_up[i]); end
            tick();
            vectors++;
            if (count !== exp_up[i]) begin miscompares++; $display("FAIL bnd_up[%0d]: got %0d expected %0d", i, count, exp_up[i]); end
        end
        vectors++;
        if (ovf !== 1'b1) begin miscompares++; $display("FAIL bnd_up_ovf: got %0b expected 1", ovf); end
        load = 1'b1; in_v = 3'd0;
        tick();
        load = 1'b0; up = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (co !== co_dn[i]) begin miscompares++; $display("FAIL bnd_dn_co[%0d]: got %0b expected %0b", i, co, co_dn[i]); end
            tick();
            vectors++;
            if (count !== exp_dn[i]) begin miscompares++; $display("FAIL bnd_dn[%0d]: got %0d expected %0d", i, count, exp_dn[i]); end
        end
        en = 1'b0;
    endtask

    task automatic test_cascade;
        logic [7:0] exp25;
        logic [7:0] exp100;
`ifdef COUNTER_SATURATE_EN
        exp25 = 8'h99; exp100 = 8'h99;
`else
        exp25 = 8'h25; exp100 = 8'h00;
`endif
        en_c = 1'b1;
        repeat (25) tick();
        vectors++;
        if ({hi_cnt, lo_cnt} !== exp25) begin miscompares++; $display("FAIL cascade_25: got %h expected %h", {hi_cnt, lo_cnt}, exp25); end
        repeat (74) tick();
        vectors++;
        if ({hi_cnt, lo_cnt} !== 8'h99) begin miscompares++; $display("FAIL cascade_99: got %h expected 99", {hi_cnt, lo_cnt}); end
        vectors++;
        if (hi_co !== 1'b1) begin miscompares++; $display("FAIL cascade_hi_co: got %0b expected 1", hi_co); end
        tick();
        vectors++;
        if ({hi_cnt, lo_cnt} !== exp100) begin miscompares++; $display("FAIL cascade_100: got %h expected %h", {hi_cnt, lo_cnt}, exp100); end
        vectors++;
        if ({hi_ovf, lo_ovf} !== 2'b11) begin miscompares++; $display("FAIL cascade_ovf: got %b expected 11", {hi_ovf, lo_ovf}); end
        en_c = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap_clear();
        test_load_priority();
        test_boundary();
        test_cascade();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_mod_nbit.md
Name: counter_mod_nbit

Overview:
- Parametrised successor of the team's 3-bit loadable counter. WIDTH-bit up/down counter with synchronous load, count enable, programmable terminal value (LIMIT), carry/borrow out and a sticky overflow flag.
- Used as a cascadable timer/index counter in the datapath controllers.
- The `co` output is combinational so that chained stages can enable the next stage in the same cycle.

Parameters:
- WIDTH, 3, counter width in bits (>=2).
- LIMIT, 2**WIDTH-1, terminal value of the count sequence 0..LIMIT (1 <= LIMIT <= 2**WIDTH-1).
- RST_VAL, 0, value of count after reset (must be <= LIMIT).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- en  input  1  count enable.
- load  input  1  synchronous parallel load.
- up  input  1  direction: 1 = increment, 0 = decrement.
- in  input  WIDTH  load value.
- clr_ovf  input  1  synchronous clear of ovf.
- count  output  WIDTH  current count, registered.
- co  output  1  terminal-count carry/borrow, combinational.
- ovf  output  1  sticky wrap/overflow flag, registered.

Behaviour:
- Reset (rst=0, asynchronous, independent of clk): count=RST_VAL, ovf=0. Reset mid-count aborts immediately. After rst deasserts, the first rising edge operates normally.
- Priority per rising edge: load > en > hold.
- load=1: count <= min(in, LIMIT), i.e. values above LIMIT are clamped to LIMIT. en and up are ignored. co is not consulted. ovf is unaffected except by clr_ovf.
- load=0, en=1, up=1:
  - count<LIMIT: count <= count+1.
  - count==LIMIT: count <= 0 (wrap).
- load=0, en=1, up=0:
  - count>0: count <= count-1.
  - count==0: count <= LIMIT (wrap).
- load=0, en=0: count holds.
- co = en & ~load & ((up & count==LIMIT) | (~up & count==0)). Purely combinational, no latency, asserted in the cycle before the wrap edge. Chaining: stage N+1 en = stage N co.
- ovf: set on any edge where a wrap (or saturation hit, see Optional Feature) occurs, i.e. co=1 at the edge.
  - clr_ovf=1 clears ovf at the edge.
  - Simultaneous set and clr_ovf: set wins (ovf=1), so no event is lost.
- Width rules: all compares and arithmetic are WIDTH bits unsigned. There is no internal carry beyond WIDTH; wrap is to 0/LIMIT, never modulo 2**WIDTH unless LIMIT=2**WIDTH-1.
- Direction change mid-count takes effect at the next enabled edge, with no bubble.
- Latency: load and count updates are visible on count one cycle after the edge at which they are sampled.

Optional Feature:
- Macro COUNTER_SATURATE_EN.
- Defined:
  - Up count at LIMIT holds LIMIT; down count at 0 holds 0, instead of wrapping.
  - co is still asserted under the same condition.
  - ovf is set on every enabled edge at the boundary.
- Undefined: wrap-around behaviour as above; no saturation logic is synthesised.

Test Plan:
1. Reset: WIDTH=3, RST_VAL=2, hold rst=0 asynchronously mid-cycle -> count=2, ovf=0 immediately, before any clk edge. Release -> count remains 2 until en.
2. Up wrap: WIDTH=3, LIMIT=5, rst released, en=1, up=1 for 7 edges -> count 1,2,3,4,5,0,1. co=1 only while count=5. ovf=1 after the 0 edge.
3. Down wrap with clear: LIMIT=5, load in=1, then en=1, up=0 -> count 1,0,5. co=1 while count=0. Then clr_ovf=1 for one edge with no wrap -> ovf=0. Then clr_ovf=1 coincident with a wrap -> ovf stays 1.
4. Load priority and clamp: LIMIT=5, en=1, load=1, in=7 -> count=5 next cycle, co=0 during load. Then load=1, in=3 with en=1 -> count=3, not 4.
5. Cascade: two instances WIDTH=4, LIMIT=9, stage-1 en tied to stage-0 co -> after 25 enabled edges, {hi,lo}={2,5}. After 100 edges -> {0,0}, with both ovf flags set.
6. COUNTER_SATURATE_EN defined, LIMIT=5, count=4, en=1, up=1 for 3 edges -> count 5,5,5, co=1 at count=5, ovf=1. Then up=0 from 0 -> count holds 0.
